// File: rtl/interp_seq_pkg.sv
// Shared types and constants for the interpolation pass sequencer.
// Holds the scan-mode and sequencer-state enums, the interpolator geometry
// constants and the two result-slicing helpers (raw and saturating).
package interp_seq_pkg;

    typedef enum logic {
        MODE_ROW = 1'b0,
        MODE_COL = 1'b1
    } mode_t;

    // The ST_ prefix keeps these literals from being hidden by the
    // sequencer's PREFILL/DRAIN parameters.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int TAP_COUNT      = 8;
    localparam int CAPTURE_OFFSET = 5;
    localparam int SLICE_LSB      = 6;
    localparam int SLICE_MSB      = 37;

    // Drop the six fractional bits and keep 32 bits of integer result.
    function automatic logic [31:0] rawSlice(input logic [39:0] value);
        return value[SLICE_MSB:SLICE_LSB];
    endfunction

    // Clamp the signed 40-bit value >> 6 into the 0..255 pixel range.
    function automatic logic [31:0] satSlice(input logic [39:0] value);
        if (value[39]) begin
            return 32'd0;
        end else if (|value[38:14]) begin
            return 32'd255;
        end else begin
            return {24'd0, value[13:6]};
        end
    endfunction

endpackage

// File: rtl/interp_addr_gen.sv
// Maps (mode, line, pos) to a plane address.
// Row mode walks along a row (line is the row index); column mode walks
// down a column (line is the column index).
module interp_addr_gen
    import interp_seq_pkg::*;
#(
    parameter int DIM    = 16,
    parameter int ADDR_W = 8,
    parameter int LINE_W = ADDR_W / 2
) (
    input  mode_t             mode,
    input  logic [LINE_W-1:0] line,
    input  logic [LINE_W-1:0] pos,
    output logic [ADDR_W-1:0] addr
);

    // A square power-of-two plane makes the mapping a plain bit concatenation.
    always_comb begin
        if (mode == MODE_COL) begin
            addr = {pos, line};
        end else begin
            addr = {line, pos};
        end
    end

endmodule

// File: rtl/interp_pass_sequencer.sv
// Sequences one row-wise or column-wise pass of the 8-tap interpolator over
// a DIM x DIM plane. For each line it issues source reads with edge
// replication (PREFILL copies of the first pixel, the line, then copies of
// the last pixel), then captures the a/b/c results into three destination
// planes.
// Optional macro INTERP_SEQ_SATURATE_EN: clamp results to 0..255 instead of
// passing the raw 32-bit slice through.
module interp_pass_sequencer
    import interp_seq_pkg::*;
#(
    parameter int DIM     = 16,
    parameter int ADDR_W  = 8,
    parameter int RD_LAT  = 1,
    parameter int PREFILL = TAP_COUNT,
    parameter int DRAIN   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              pix_rd_en,
    output logic [ADDR_W-1:0] pix_rd_addr,
    input  logic [39:0]       a_value,
    input  logic [39:0]       b_value,
    input  logic [39:0]       c_value,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_a,
    output logic [31:0]       wr_b,
    output logic [31:0]       wr_c
);

    localparam int LINE_W   = ADDR_W / 2;
    localparam int SLOTS    = PREFILL + DIM + DRAIN + RD_LAT;
    localparam int SLOT_W   = $clog2(SLOTS);
    localparam int WR_FIRST = PREFILL + CAPTURE_OFFSET + RD_LAT;

    localparam logic [SLOT_W-1:0] LAST_SLOT    = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] STREAM_FIRST = SLOT_W'(PREFILL);
    localparam logic [SLOT_W-1:0] DRAIN_FIRST  = SLOT_W'(PREFILL + DIM);
    localparam logic [SLOT_W-1:0] WR_LO        = SLOT_W'(WR_FIRST);
    localparam logic [SLOT_W-1:0] WR_HI        = SLOT_W'(WR_FIRST + DIM - 1);
    localparam logic [LINE_W-1:0] LAST_LINE    = LINE_W'(DIM - 1);

    state_t              state, nextState;
    mode_t               modeReg, nextMode;
    logic [LINE_W-1:0]   line, nextLine;
    logic [SLOT_W-1:0]   slot, nextSlot;
    logic                nextActive;
    logic                nextWrEn;
    logic [LINE_W-1:0]   rdPos, wrPos;
    logic [ADDR_W-1:0]   rdAddrNext, wrAddrNext;
    logic                unusedBits;

    function automatic state_t phaseOf(input logic [SLOT_W-1:0] s);
        if (s < STREAM_FIRST) begin
            return ST_PREFILL;
        end else if (s < DRAIN_FIRST) begin
            return ST_STREAM;
        end else begin
            return ST_DRAIN;
        end
    endfunction

    // Next-state decode: walk the slots of a line, then the lines of the plane.
    always_comb begin
        nextState = state;
        nextSlot  = slot;
        nextLine  = line;
        nextMode  = modeReg;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nextState = ST_PREFILL;
                    nextSlot  = '0;
                    nextLine  = '0;
                    nextMode  = mode_t'(mode);
                end
            end
            ST_PREFILL, ST_STREAM, ST_DRAIN: begin
                if (slot == LAST_SLOT) begin
                    nextSlot = '0;
                    if (line == LAST_LINE) begin
                        nextState = ST_DONE;
                        nextLine  = '0;
                    end else begin
                        nextState = ST_PREFILL;
                        nextLine  = line + LINE_W'(1);
                    end
                end else begin
                    nextSlot  = slot + SLOT_W'(1);
                    nextState = phaseOf(slot + SLOT_W'(1));
                end
            end
            ST_DONE: begin
                nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    // Position along the line for the upcoming read and write slots.
    always_comb begin
        nextActive = (nextState == ST_PREFILL) || (nextState == ST_STREAM) ||
                     (nextState == ST_DRAIN);
        nextWrEn   = nextActive && (nextSlot >= WR_LO) && (nextSlot <= WR_HI);
        rdPos      = '0;
        case (nextState)
            ST_STREAM: rdPos = LINE_W'(nextSlot - STREAM_FIRST);
            ST_DRAIN:  rdPos = LAST_LINE;
            default:   rdPos = '0;
        endcase
        wrPos = LINE_W'(nextSlot - WR_LO);
    end

    interp_addr_gen #(
        .DIM    (DIM),
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) rdAddrGen (
        .mode (nextMode),
        .line (nextLine),
        .pos  (rdPos),
        .addr (rdAddrNext)
    );

    interp_addr_gen #(
        .DIM    (DIM),
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) wrAddrGen (
        .mode (nextMode),
        .line (nextLine),
        .pos  (wrPos),
        .addr (wrAddrNext)
    );

    // Sequencer state and all registered outputs, loaded from the next-slot decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            modeReg     <= MODE_ROW;
            line        <= '0;
            slot        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pix_rd_en   <= 1'b0;
            pix_rd_addr <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
        end else begin
            state       <= nextState;
            modeReg     <= nextMode;
            line        <= nextLine;
            slot        <= nextSlot;
            busy        <= nextActive;
            done        <= (nextState == ST_DONE);
            pix_rd_en   <= nextActive;
            pix_rd_addr <= nextActive ? rdAddrNext : '0;
            wr_en       <= nextWrEn;
            wr_addr     <= nextWrEn ? wrAddrNext : '0;
        end
    end

    // Result slicing straight from the interpolator, zeroed outside the capture window.
    always_comb begin
        wr_a = 32'd0;
        wr_b = 32'd0;
        wr_c = 32'd0;
        if (wr_en) begin
`ifdef INTERP_SEQ_SATURATE_EN
            wr_a = satSlice(a_value);
            wr_b = satSlice(b_value);
            wr_c = satSlice(c_value);
`else
            wr_a = rawSlice(a_value);
            wr_b = rawSlice(b_value);
            wr_c = rawSlice(c_value);
`endif
        end
    end

    // Fractional and guard bits never reach the destination planes.
    assign unusedBits = ^{a_value[39:38], a_value[5:0],
                          b_value[39:38], b_value[5:0],
                          c_value[39:38], c_value[5:0]};

endmodule

// File: tb/tb_interp_pass_sequencer.sv
// Directed bench for interp_pass_sequencer at default parameters.
// A small memory + one-register interpolator model feeds a constant plane of
// 100 back into the sequencer; a_value can be overridden for slicing tests.
module tb_interp_pass_sequencer;

    localparam int DIM         = 16;
    localparam int ADDR_W      = 8;
    localparam int SLOTS       = 30;
    localparam int PASS_CYCLES = DIM * SLOTS;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              mode;
    logic              busy;
    logic              done;
    logic              pix_rd_en;
    logic [ADDR_W-1:0] pix_rd_addr;
    logic [39:0]       a_value;
    logic [39:0]       b_value;
    logic [39:0]       c_value;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_a;
    logic [31:0]       wr_b;
    logic [31:0]       wr_c;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  plane [256];
    logic [7:0]  memQ;
    logic [7:0]  interpQ;
    logic        useOverride = 1'b0;
    logic [39:0] overrideA   = '0;

    interp_pass_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .busy        (busy),
        .done        (done),
        .pix_rd_en   (pix_rd_en),
        .pix_rd_addr (pix_rd_addr),
        .a_value     (a_value),
        .b_value     (b_value),
        .c_value     (c_value),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_a        (wr_a),
        .wr_b        (wr_b),
        .wr_c        (wr_c)
    );

    always #5 clock = ~clock;

    // One cycle of memory latency, then one interpolator register.
    always @(posedge clock) begin
        memQ    <= plane[pix_rd_addr];
        interpQ <= memQ;
    end

    assign a_value = useOverride ? overrideA : {26'd0, interpQ, 6'h2A};
    assign b_value = {26'd0, interpQ, 6'h11};
    assign c_value = {26'd0, interpQ, 6'h3F};

    // Position along a line for slot s: 8 x first pixel, the line, 6 x last pixel.
    function automatic int expRdPos(input int s);
        if (s < 8) return 0;
        else if (s < 24) return s - 8;
        else return 15;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%0b expected=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done actual=%0b expected=0", done); end
        checks++; if (pix_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_en actual=%0b expected=0", pix_rd_en); end
        checks++; if (pix_rd_addr !== 8'd0) begin failures++; $display("[TB] FAIL reset_rd_addr actual=%0d expected=0", pix_rd_addr); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en actual=%0b expected=0", wr_en); end
        checks++; if (wr_addr !== 8'd0) begin failures++; $display("[TB] FAIL reset_wr_addr actual=%0d expected=0", wr_addr); end
        checks++; if (wr_a !== 32'd0) begin failures++; $display("[TB] FAIL reset_wr_a actual=%0d expected=0", wr_a); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_busy actual=%0b expected=0", busy); end
    endtask

    // Row pass with a repeated start at cycles 50 (busy) and 481 (done), and mode flipped mid-pass.
    task automatic test_row_pass();
        int writes  = 0;
        int firstWr = -1;
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= PASS_CYCLES + 5; c++) begin
            checks++; if (busy !== (c <= PASS_CYCLES)) begin failures++; $display("[TB] FAIL row_busy cycle=%0d actual=%0b expected=%0b", c, busy, c <= PASS_CYCLES); end
            checks++; if (done !== (c == PASS_CYCLES + 1)) begin failures++; $display("[TB] FAIL row_done cycle=%0d actual=%0b expected=%0b", c, done, c == PASS_CYCLES + 1); end
            checks++; if (pix_rd_en !== (c <= PASS_CYCLES)) begin failures++; $display("[TB] FAIL row_rd_en cycle=%0d actual=%0b expected=%0b", c, pix_rd_en, c <= PASS_CYCLES); end
            if (c <= SLOTS) begin
                checks++; if (pix_rd_addr !== 8'(expRdPos(c - 1))) begin failures++; $display("[TB] FAIL row_rd_addr cycle=%0d actual=%0d expected=%0d", c, pix_rd_addr, expRdPos(c - 1)); end
            end
            if (wr_en === 1'b1) begin
                if (firstWr < 0) firstWr = c;
                checks++; if (wr_addr !== 8'(writes)) begin failures++; $display("[TB] FAIL row_wr_addr cycle=%0d actual=%0d expected=%0d", c, wr_addr, writes); end
                checks++; if (wr_a !== 32'd100) begin failures++; $display("[TB] FAIL row_wr_a cycle=%0d actual=%0d expected=100", c, wr_a); end
                checks++; if (wr_b !== 32'd100) begin failures++; $display("[TB] FAIL row_wr_b cycle=%0d actual=%0d expected=100", c, wr_b); end
                checks++; if (wr_c !== 32'd100) begin failures++; $display("[TB] FAIL row_wr_c cycle=%0d actual=%0d expected=100", c, wr_c); end
                writes++;
            end else begin
                checks++; if (wr_a !== 32'd0) begin failures++; $display("[TB] FAIL row_wr_a_gated cycle=%0d actual=%0d expected=0", c, wr_a); end
            end
            start = (c == 50) || (c == PASS_CYCLES + 1);
            mode  = (c >= 60);
            @(negedge clock);
        end
        start = 1'b0;
        mode  = 1'b0;
        checks++; if (writes !== 256) begin failures++; $display("[TB] FAIL row_write_count actual=%0d expected=256", writes); end
        checks++; if (firstWr !== 15) begin failures++; $display("[TB] FAIL row_first_write actual=%0d expected=15", firstWr); end
    endtask

    task automatic test_col_pass();
        int writes    = 0;
        int doneCycle = -1;
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        mode  = 1'b0;
        for (int c = 1; c <= PASS_CYCLES + 3; c++) begin
            if (c <= SLOTS) begin
                checks++; if (pix_rd_addr !== 8'(expRdPos(c - 1) * 16)) begin failures++; $display("[TB] FAIL col_rd_addr cycle=%0d actual=%0d expected=%0d", c, pix_rd_addr, expRdPos(c - 1) * 16); end
            end
            if (wr_en === 1'b1) begin
                checks++; if (wr_addr !== 8'((writes % 16) * 16 + writes / 16)) begin failures++; $display("[TB] FAIL col_wr_addr cycle=%0d actual=%0d expected=%0d", c, wr_addr, (writes % 16) * 16 + writes / 16); end
                writes++;
            end
            if (done === 1'b1 && doneCycle < 0) doneCycle = c;
            @(negedge clock);
        end
        checks++; if (writes !== 256) begin failures++; $display("[TB] FAIL col_write_count actual=%0d expected=256", writes); end
        checks++; if (doneCycle !== PASS_CYCLES + 1) begin failures++; $display("[TB] FAIL col_done_cycle actual=%0d expected=%0d", doneCycle, PASS_CYCLES + 1); end
    endtask

    task automatic test_reset_mid_pass();
        int busyCount = 0;
        int writes    = 0;
        int doneCycle = -1;
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (99) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (pix_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL abort_rd_en actual=%0b expected=0", pix_rd_en); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("[TB] FAIL abort_wr_en actual=%0b expected=0", wr_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy actual=%0b expected=0", busy); end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            checks++; if ({busy, pix_rd_en, wr_en, done} !== 4'b0000) begin failures++; $display("[TB] FAIL abort_idle cycle=%0d actual=%b expected=0000", c, {busy, pix_rd_en, wr_en, done}); end
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= PASS_CYCLES + 20; c++) begin
            if (busy === 1'b1) busyCount++;
            if (wr_en === 1'b1) writes++;
            if (done === 1'b1 && doneCycle < 0) doneCycle = c;
            if (doneCycle > 0 && c > doneCycle + 2) break;
            @(negedge clock);
        end
        checks++; if (busyCount !== PASS_CYCLES) begin failures++; $display("[TB] FAIL restart_busy_cycles actual=%0d expected=%0d", busyCount, PASS_CYCLES); end
        checks++; if (writes !== 256) begin failures++; $display("[TB] FAIL restart_write_count actual=%0d expected=256", writes); end
        checks++; if (doneCycle !== PASS_CYCLES + 1) begin failures++; $display("[TB] FAIL restart_done_cycle actual=%0d expected=%0d", doneCycle, PASS_CYCLES + 1); end
    endtask

    task automatic test_saturation();
        logic [31:0] expNeg;
        logic [31:0] exp300;
        int          waited = 0;
`ifdef INTERP_SEQ_SATURATE_EN
        expNeg = 32'd0;
        exp300 = 32'd255;
`else
        expNeg = 32'hFFFF_FFFF;
        exp300 = 32'd300;
`endif
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clock);
        start = 1'b0;
        while (wr_en !== 1'b1 && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        checks++; if (wr_en !== 1'b1) begin failures++; $display("[TB] FAIL sat_window_timeout actual=%0b expected=1", wr_en); end
        useOverride = 1'b1;
        overrideA   = 40'hFF_FFFF_FFC0;
        #1;
        checks++; if (wr_a !== expNeg) begin failures++; $display("[TB] FAIL sat_negative actual=%0h expected=%0h", wr_a, expNeg); end
        overrideA = 40'd300 << 6;
        #1;
        checks++; if (wr_a !== exp300) begin failures++; $display("[TB] FAIL sat_300 actual=%0d expected=%0d", wr_a, exp300); end
        overrideA = 40'd200 << 6;
        #1;
        checks++; if (wr_a !== 32'd200) begin failures++; $display("[TB] FAIL sat_200 actual=%0d expected=200", wr_a); end
        checks++; if (wr_b !== 32'd100) begin failures++; $display("[TB] FAIL sat_b_untouched actual=%0d expected=100", wr_b); end
        useOverride = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Run every scenario in order, then report.
    initial begin
        for (int i = 0; i < 256; i++) plane[i] = 8'd100;
        test_reset();
        test_row_pass();
        test_col_pass();
        test_reset_mid_pass();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interp_pass_sequencer.md
Name: interp_pass_sequencer

Overview:
- Sequences one separable interpolation pass of the 8-tap `interpolator` over a DIM x DIM plane, either row-wise (ABC) or column-wise (DHN).
- Per line it generates source read addresses with edge replication: 8 copies of the first pixel, then the line, then copies of the last pixel.
- It captures the interpolator's a/b/c results into three destination planes with write strobes and addresses.
- It sits between the plane memories and the interpolator; a top-level controller issues one pass per start.

Parameters:
- DIM, 16, plane width/height in pixels (power of 2)
- ADDR_W, 8, log2(DIM*DIM), plane address width
- RD_LAT, 1, source memory read latency in cycles (0..2)
- PREFILL, 8, leading replicated-pixel slots per line (equals interpolator tap count)
- DRAIN, 5, trailing replicated-pixel slots before RD_LAT compensation

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begin pass when idle
- mode  in  1  0 = row pass, 1 = column pass; sampled with start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after last write
- pix_rd_en  out  1  source read strobe
- pix_rd_addr  out  ADDR_W  source pixel address
- a_value  in  40  interpolator a result
- b_value  in  40  interpolator b result
- c_value  in  40  interpolator c result
- wr_en  out  1  destination write strobe (all three planes)
- wr_addr  out  ADDR_W  destination address
- wr_a  out  32  a result to plane A/D
- wr_b  out  32  b result to plane B/H
- wr_c  out  32  c result to plane C/N

Behaviour:
- Reset (async, active-high) forces state IDLE, counters 0, and all outputs 0 immediately.
- Line count and position:
  - line = 0..DIM-1 (row index in row mode, column index in column mode).
  - pos = position along the line.
  - Row mode: addr = line*DIM + pos. Column mode: addr = pos*DIM + line.
  - Destination uses the same mapping as the source.
- Slot counter s runs 0..SLOTS-1 per line, with SLOTS = PREFILL + DIM + DRAIN + RD_LAT (30 at defaults).
- States and transitions:
  - IDLE –start→ PREFILL.
  - PREFILL (s < PREFILL): pos = 0.
  - STREAM (PREFILL ≤ s < PREFILL+DIM): pos = s - PREFILL.
  - DRAIN (remaining slots): pos = DIM-1.
  - At the last slot: line++ and return to PREFILL. If line == DIM-1, go to DONE instead.
  - DONE: one cycle; done = 1, busy = 0, then IDLE.
- Address outputs: pix_rd_en = 1 and pix_rd_addr registered in every PREFILL/STREAM/DRAIN cycle; both are 0 in IDLE and DONE.
- Capture window:
  - wr_en = 1 for s in [PREFILL+5+RD_LAT, PREFILL+20+RD_LAT], exactly DIM writes per line.
  - wr_addr maps pos_w = s - (PREFILL+5+RD_LAT).
  - The interpolator registers data one cycle after memory returns it, so a_value sampled in slot s covers taps pos_w-3..pos_w+4.
- Result slicing: wr_x = x_value[37:6]; wr_* are combinational from inputs, gated to 0 when wr_en = 0.
- Latency at defaults:
  - Start sampled at edge 0; first pix_rd_en in cycle 1; first wr_en in cycle 15.
  - Pass length DIM*SLOTS = 480 cycles; done in cycle 481.
- Boundary conditions:
  - start while busy: ignored.
  - start in DONE cycle: ignored.
  - mode change while busy: ignored.
  - Reset mid-pass: abort; no further writes; restart only by new start.

Optional Feature:
- Macro INTERP_SEQ_SATURATE_EN.
- Defined:
  - wr_x clamps the signed 40-bit x_value>>6 to 0..255.
  - Negative (bit 39 = 1) → 0; above 255 → 255.
- Undefined: raw slice x_value[37:6] with no clamping.

Decomposition:
- Package interp_seq_pkg:
  - mode enum MODE_ROW/MODE_COL.
  - state enum IDLE/PREFILL/STREAM/DRAIN/DONE.
  - Constants for tap count 8, capture offset 5, result slice LSB 6/MSB 37.
- Sub-module interp_addr_gen: combinational (mode, line, pos) → address, instantiated twice (read, write).

Test Plan:
- Row pass, RD_LAT=1, constant plane 100, bench interpolator → 256 writes, all wr_a/b/c = 100; wr_addr sequence 0,1,…,255; done in cycle 481.
- Row pass, line 0 read trace → pix_rd_addr = 0 ×8, then 0..15, then 15 ×6; first wr_en in cycle 15 with wr_addr 0.
- Column pass → first line reads 0 ×8, 0,16,…,240, then 240 ×6; wr_addr sequence 0,16,…,240, then 1,17,….
- start asserted again at cycles 50 and 481 → no effect; busy stays 1 until done; exactly 256 writes.
- Reset asserted at cycle 100 → pix_rd_en, wr_en, busy = 0 in the same cycle; after release, outputs stay idle until the next start, then a full 480-cycle pass.
- Saturation, a_value driven directly:
  - a_value = 40'hFF_FFFF_FFC0 → wr_a = 0 with INTERP_SEQ_SATURATE_EN, 32'hFFFF_FFFF without.
  - a_value = 300<<6 → 255 with the macro, 300 without.
